mem_wb: RTL and testbench

//  Final pipeline stage after id_ex/EX: latches EX results, waits for the data-phase reply of a

---
 rtl/mem_wb_pkg.sv | 31 +++
 rtl/mem_wb_load_align.sv | 35 +++
 rtl/mem_wb.sv | 121 ++++++++++++
 tb/tb_mem_wb.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// Shared constants and types for the MEM/WB stage: data widths, load funct3 codes,
// control_flow bit positions and the latched instruction record.
package mem_wb_pkg;

  localparam int DATA_W = 32;
  localparam int RD_W   = 5;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  localparam int CF_MEM_READ  = 3;
  localparam int CF_MEM_WRITE = 2;
  localparam int CF_MEM2REG   = 1;
  localparam int CF_WRITE_REG = 0;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] alu_result;
    logic [2:0]        funct3;
    logic [3:0]        control_flow;
  } wb_fields_t;

  function automatic logic is_mem_op(input logic [3:0] cf);
    return cf[CF_MEM_READ] | cf[CF_MEM_WRITE];
  endfunction

endpackage

// File: rtl/mem_wb_load_align.sv
// Selects the addressed byte/halfword of a loaded word and sign- or zero-extends it
// according to the load's funct3.
module mem_wb_load_align
  import mem_wb_pkg::*;
(
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        off_i,
  output logic [DATA_W-1:0] load_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (off_i)
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      2'd3:    byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    // Unrecognised funct3 codes pass the raw word through, same as lw
    case (funct3_i)
      LD_LB:   load_data_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LD_LBU:  load_data_o = {{(DATA_W-8){1'b0}}, byte_sel};
      LD_LH:   load_data_o = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LD_LHU:  load_data_o = {{(DATA_W-16){1'b0}}, half_sel};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_wb.sv
// Final pipeline stage: latches EX results, waits for the data-phase reply of split
// data-RAM transactions, drops replies of flushed requests and drives regfile writeback.
module mem_wb
  import mem_wb_pkg::*;
#(
  parameter int CANCEL_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              hold,
  input  logic              valid_ex,
  input  logic              ready_go_ex,
  input  logic [DATA_W-1:0] pc_ex,
  input  logic [RD_W-1:0]   rd_ex,
  input  logic [DATA_W-1:0] alu_result_ex,
  input  logic [2:0]        funct3_ex,
  input  logic [3:0]        control_flow_ex,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              allow_in_wb,
  output logic              valid_wb,
  output logic              ready_go_wb,
  output logic [DATA_W-1:0] pc_wb,
  output logic [RD_W-1:0]   rd_wb,
  output logic              reg_we_wb,
  output logic [DATA_W-1:0] reg_wdata_wb,
  output logic              fwd_we_wb
);

  wb_fields_t          ex_fields, fields_q, fields_d;
  logic                valid_q, valid_d;
  logic                buf_valid_q, buf_valid_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic [CANCEL_W-1:0] discard_cnt_q, discard_cnt_d;
  logic [DATA_W-1:0]   load_src, load_data;
  logic                pipe_valid, ex_mem, mem_type, data_hit;
  logic                ready_go, allow_core, retire;
  logic                cancel_inc, cancel_dec;

  assign ex_fields = '{pc: pc_ex, rd: rd_ex, alu_result: alu_result_ex,
                       funct3: funct3_ex, control_flow: control_flow_ex};

  assign pipe_valid = valid_ex & ready_go_ex & ~flush;
  assign ex_mem     = is_mem_op(control_flow_ex);
  assign mem_type   = is_mem_op(fields_q.control_flow);
  // A reply belongs to the resident op only once all cancelled requests have drained
  assign data_hit   = mem_data_ok & (discard_cnt_q == '0);
  assign ready_go   = valid_q & (~mem_type | buf_valid_q | data_hit);
  assign allow_core = ~valid_q | (ready_go & ~hold);
  assign retire     = valid_q & ready_go & ~hold;
  assign cancel_inc = valid_ex & ready_go_ex & ex_mem & flush;
  assign cancel_dec = mem_data_ok & (discard_cnt_q != '0);

  always_comb begin
    valid_d       = valid_q;
    fields_d      = fields_q;
    buf_valid_d   = buf_valid_q;
    buf_d         = buf_q;
    discard_cnt_d = discard_cnt_q;

    if (allow_core) begin
      valid_d = pipe_valid;
      if (pipe_valid) fields_d = ex_fields;
    end

    if (retire) begin
      buf_valid_d = 1'b0;
    end else if (data_hit & valid_q & mem_type) begin
      buf_valid_d = 1'b1;
      buf_d       = mem_rdata;
    end

    case ({cancel_inc, cancel_dec})
      2'b10:   discard_cnt_d = discard_cnt_q + CANCEL_W'(1);
      2'b01:   discard_cnt_d = discard_cnt_q - CANCEL_W'(1);
      default: discard_cnt_d = discard_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q       <= 1'b0;
      fields_q      <= '0;
      buf_valid_q   <= 1'b0;
      buf_q         <= '0;
      discard_cnt_q <= '0;
    end else begin
      valid_q       <= valid_d;
      fields_q      <= fields_d;
      buf_valid_q   <= buf_valid_d;
      buf_q         <= buf_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

  assign load_src = buf_valid_q ? buf_q : mem_rdata;

  mem_wb_load_align u_load_align (
    .rdata_i     (load_src),
    .funct3_i    (fields_q.funct3),
    .off_i       (fields_q.alu_result[1:0]),
    .load_data_o (load_data)
  );

  assign allow_in_wb  = rst_n & allow_core;
  assign valid_wb     = valid_q;
  assign ready_go_wb  = ready_go;
  assign pc_wb        = fields_q.pc;
  assign rd_wb        = fields_q.rd;
  assign reg_we_wb    = retire & fields_q.control_flow[CF_WRITE_REG];
  assign reg_wdata_wb = fields_q.control_flow[CF_MEM2REG] ? load_data : fields_q.alu_result;
  assign fwd_we_wb    = valid_q & fields_q.control_flow[CF_WRITE_REG];

  a_no_double_reply: assert property (@(posedge clk) disable iff (!rst_n)
    !(data_hit && buf_valid_q));

  a_discard_no_saturate: assert property (@(posedge clk) disable iff (!rst_n)
    !(cancel_inc && !cancel_dec && (discard_cnt_q == '1)));

endmodule

// File: tb/tb_mem_wb.sv
// Self-checking bench for mem_wb: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_wb;
  import mem_wb_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush, hold, valid_ex, ready_go_ex;
  logic [DATA_W-1:0] pc_ex, alu_result_ex, mem_rdata;
  logic [RD_W-1:0]   rd_ex;
  logic [2:0]        funct3_ex;
  logic [3:0]        control_flow_ex;
  logic              mem_data_ok;
  logic              allow_in_wb, valid_wb, ready_go_wb, reg_we_wb, fwd_we_wb;
  logic [DATA_W-1:0] pc_wb, reg_wdata_wb;
  logic [RD_W-1:0]   rd_wb;

  mem_wb #(.CANCEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .hold(hold),
    .valid_ex(valid_ex), .ready_go_ex(ready_go_ex), .pc_ex(pc_ex), .rd_ex(rd_ex),
    .alu_result_ex(alu_result_ex), .funct3_ex(funct3_ex), .control_flow_ex(control_flow_ex),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .allow_in_wb(allow_in_wb), .valid_wb(valid_wb), .ready_go_wb(ready_go_wb),
    .pc_wb(pc_wb), .rd_wb(rd_wb), .reg_we_wb(reg_we_wb), .reg_wdata_wb(reg_wdata_wb),
    .fwd_we_wb(fwd_we_wb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycleNo = 0;

  // Model: the instruction sitting in the stage plus the in-order list of memory requests
  // whose reply is still owed (live = belongs to a real instruction, else cancelled).
  typedef struct {
    bit live;
    int readyAt;
  } txn_t;
  txn_t pend[$];

  bit          mValid, mBufValid, mResetSeen;
  logic [31:0] mPc, mAlu, mBuf;
  logic [4:0]  mRd;
  logic [2:0]  mF3;
  logic [3:0]  mCf;

  bit          expReady, expAllow, expRetire, expWe, expFwd;
  logic [31:0] expWdata;

  logic        sValid, sReady, sAllow, sWe, sFwd;
  logic [31:0] sWdata, sPc;
  logic [4:0]  sRd;

  function automatic logic [31:0] modelLoad(input logic [31:0] word, input logic [2:0] f3,
                                            input logic [1:0] off);
    logic [31:0]        byteShift, halfShift;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    byteShift = word >> (8 * off);
    halfShift = word >> (16 * off[1]);
    sb = byteShift[7:0];
    sh = halfShift[15:0];
    case (f3)
      3'b000:  return 32'(sb);
      3'b100:  return 32'(byteShift[7:0]);
      3'b001:  return 32'(sh);
      3'b101:  return 32'(halfShift[15:0]);
      default: return word;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h", name, cycleNo, act, exp);
    end
  endtask

  task automatic modelEval();
    bit replyLive, isMem, haveData;
    logic [31:0] word;
    replyLive = mem_data_ok && (pend.size() > 0) && pend[0].live;
    isMem     = mCf[3] | mCf[2];
    haveData  = mBufValid || replyLive;
    expReady  = mValid && (!isMem || haveData);
    expAllow  = rst_n && (!mValid || (expReady && !hold));
    expRetire = expReady && !hold;
    expWe     = expRetire && mCf[0];
    expFwd    = mValid && mCf[0];
    word      = mBufValid ? mBuf : mem_rdata;
    expWdata  = mCf[1] ? modelLoad(word, mF3, mAlu[1:0]) : mAlu;
  endtask

  // Called right after a falling edge with inputs already driven; returns at the next one.
  task automatic applyStimulus();
    bit replyLive, pipe, exMem;
    #1;
    modelEval();
    {sValid, sReady, sAllow, sWe, sFwd} = {valid_wb, ready_go_wb, allow_in_wb, reg_we_wb, fwd_we_wb};
    {sWdata, sPc, sRd} = {reg_wdata_wb, pc_wb, rd_wb};

    if (rst_n || mResetSeen) begin
      checkOutput("valid_wb", 32'(sValid), 32'(mValid));
      checkOutput("ready_go_wb", 32'(sReady), 32'(expReady));
      checkOutput("allow_in_wb", 32'(sAllow), 32'(expAllow));
      checkOutput("reg_we_wb", 32'(sWe), 32'(expWe));
      checkOutput("fwd_we_wb", 32'(sFwd), 32'(expFwd));
      checkOutput("pc_wb", sPc, mPc);
      checkOutput("rd_wb", 32'(sRd), 32'(mRd));
      if (expWe || !rst_n) checkOutput("reg_wdata_wb", sWdata, expWdata);
    end

    replyLive = 1'b0;
    if (mem_data_ok && rst_n) begin
      if (pend.size() == 0) begin
        errors++;
        $display("[TB] FAIL stimulus: reply with nothing outstanding (cycle %0d)", cycleNo);
      end else begin
        replyLive = pend[0].live;
        void'(pend.pop_front());
      end
    end

    pipe  = valid_ex && ready_go_ex && !flush;
    exMem = control_flow_ex[3] | control_flow_ex[2];
    if (!rst_n) begin
      {mValid, mBufValid} = '0;
      {mPc, mAlu, mBuf, mRd, mF3, mCf} = '0;
      pend.delete();
      mResetSeen = 1'b1;
    end else begin
      mResetSeen = 1'b0;
      if (valid_ex && ready_go_ex && exMem && (flush || expAllow))
        pend.push_back('{live: !flush, readyAt: cycleNo + 1});
      if (expRetire) mBufValid = 1'b0;
      else if (replyLive) begin
        mBufValid = 1'b1;
        mBuf      = mem_rdata;
      end
      if (expAllow) begin
        mValid = pipe;
        if (pipe) {mPc, mRd, mAlu, mF3, mCf} = {pc_ex, rd_ex, alu_result_ex, funct3_ex, control_flow_ex};
      end
    end
    cycleNo++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic exIdle();
    {valid_ex, ready_go_ex, flush} = 3'b000;
    {pc_ex, alu_result_ex, rd_ex, funct3_ex, control_flow_ex} = '0;
  endtask

  task automatic exOp(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] alu,
                      input logic [2:0] f3, input logic [3:0] cf, input bit fl);
    {valid_ex, ready_go_ex, flush} = {2'b11, fl};
    {pc_ex, rd_ex, alu_result_ex, funct3_ex, control_flow_ex} = {pc, rd, alu, f3, cf};
  endtask

  task automatic reply(input bit ok, input logic [31:0] data);
    mem_data_ok = ok;
    mem_rdata   = data;
  endtask

  initial begin
    int kind, cancelled;
    bit liveOutstanding, canCancel;

    rst_n = 1'b0;
    hold  = 1'b0;
    exIdle();
    reply(0, 32'hDEAD_BEEF);
    @(negedge clk);
    applyStimulus();
    applyStimulus();
    checkOutput("reset_valid", 32'(sValid), 0);
    checkOutput("reset_we", 32'(sWe), 0);
    rst_n = 1'b1;

    checkOutput("pin_lb", modelLoad(32'h8000_0000, LD_LB, 2'd3), 32'hFFFF_FF80);
    checkOutput("pin_lhu", modelLoad(32'hBEEF_0000, LD_LHU, 2'd2), 32'h0000_BEEF);
    checkOutput("pin_lh", modelLoad(32'h0000_8001, LD_LH, 2'd1), 32'hFFFF_8001);
    checkOutput("pin_lbu", modelLoad(32'h0000_AB00, LD_LBU, 2'd1), 32'h0000_00AB);
    checkOutput("pin_lw", modelLoad(32'hCAFE_F00D, LD_LW, 2'd3), 32'hCAFE_F00D);

    // ALU op commits one cycle after entry
    exOp(32'h100, 5'd5, 32'h1234_5678, 3'b000, 4'b0001, 0);
    applyStimulus();
    checkOutput("alu_entry_allow", 32'(sAllow), 1);
    exIdle();
    applyStimulus();
    checkOutput("alu_we", 32'(sWe), 1);
    checkOutput("alu_wdata", sWdata, 32'h1234_5678);
    checkOutput("alu_rd", 32'(sRd), 5);
    applyStimulus();
    checkOutput("alu_we_once", 32'(sWe), 0);

    // lb at offset 3, reply two cycles after entry
    exOp(32'h104, 5'd6, 32'h0000_1003, LD_LB, 4'b1011, 0);
    applyStimulus();
    exIdle();
    applyStimulus();
    checkOutput("lb_wait1", 32'(sReady), 0);
    applyStimulus();
    checkOutput("lb_wait2", 32'(sReady), 0);
    reply(1, 32'h8000_0000);
    applyStimulus();
    checkOutput("lb_ready", 32'(sReady), 1);
    checkOutput("lb_wdata", sWdata, 32'hFFFF_FF80);
    reply(0, 32'hDEAD_BEEF);

    // lhu reply arrives under hold and must be buffered
    exOp(32'h108, 5'd7, 32'h0000_2002, LD_LHU, 4'b1011, 0);
    applyStimulus();
    exIdle();
    hold = 1'b1;
    reply(1, 32'hBEEF_0000);
    applyStimulus();
    checkOutput("lhu_held_we", 32'(sWe), 0);
    reply(0, 32'h1234_5678);
    applyStimulus();
    applyStimulus();
    checkOutput("lhu_held_allow", 32'(sAllow), 0);
    hold = 1'b0;
    applyStimulus();
    checkOutput("lhu_we", 32'(sWe), 1);
    checkOutput("lhu_wdata", sWdata, 32'h0000_BEEF);

    // Store waits for its ack; next ALU op enters in the retire cycle
    exOp(32'h10C, 5'd0, 32'h0000_3000, LD_LW, 4'b0100, 0);
    applyStimulus();
    exIdle();
    applyStimulus();
    checkOutput("st_wait_allow", 32'(sAllow), 0);
    reply(1, 32'h0);
    exOp(32'h110, 5'd8, 32'h0000_00A5, 3'b000, 4'b0001, 0);
    applyStimulus();
    checkOutput("st_we", 32'(sWe), 0);
    checkOutput("st_allow", 32'(sAllow), 1);
    exIdle();
    reply(0, 32'hDEAD_BEEF);
    applyStimulus();
    checkOutput("b2b_we", 32'(sWe), 1);
    checkOutput("b2b_wdata", sWdata, 32'h0000_00A5);

    // Flushed load: its reply is dropped, the following load uses only its own data
    exOp(32'h114, 5'd9, 32'h0000_4000, LD_LW, 4'b1011, 1);
    applyStimulus();
    exOp(32'h118, 5'd10, 32'h0000_4001, LD_LBU, 4'b1011, 0);
    applyStimulus();
    checkOutput("flush_not_entered", 32'(sValid), 0);
    exIdle();
    reply(1, 32'h1111_1111);
    applyStimulus();
    checkOutput("stale_ready", 32'(sReady), 0);
    checkOutput("stale_we", 32'(sWe), 0);
    reply(1, 32'h0000_AB00);
    applyStimulus();
    checkOutput("own_we", 32'(sWe), 1);
    checkOutput("own_wdata", sWdata, 32'h0000_00AB);
    reply(0, 32'hDEAD_BEEF);

    // Reset while a load is outstanding
    exOp(32'h11C, 5'd11, 32'h0000_5000, LD_LW, 4'b1011, 0);
    applyStimulus();
    exIdle();
    applyStimulus();
    rst_n = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_valid", 32'(sValid), 0);
    checkOutput("rst_we", 32'(sWe), 0);
    checkOutput("rst_pc", sPc, 0);
    checkOutput("rst_wdata", sWdata, 0);
    checkOutput("rst_fwd", 32'(sFwd), 0);
    rst_n = 1'b1;
    applyStimulus();
    checkOutput("post_rst_we", 32'(sWe), 0);

    for (int n = 0; n < 3000; n++) begin
      reply(0, $urandom);
      if (pend.size() > 0 && pend[0].readyAt <= cycleNo && $urandom_range(0, 1) == 1)
        mem_data_ok = 1'b1;
      hold = ($urandom_range(0, 3) == 0);
      modelEval();

      liveOutstanding = 1'b0;
      cancelled = 0;
      for (int i = 0; i < pend.size(); i++) begin
        if (pend[i].live) liveOutstanding = 1'b1;
        else cancelled++;
      end
      canCancel = !liveOutstanding && (cancelled < 3);

      kind = $urandom_range(0, 3);
      flush = ($urandom_range(0, 7) == 0);
      valid_ex = (kind != 0);
      pc_ex = $urandom;
      rd_ex = 5'($urandom);
      alu_result_ex = $urandom;
      funct3_ex = 3'($urandom);
      case (kind)
        1:       control_flow_ex = {3'b000, 1'($urandom)};
        2:       control_flow_ex = 4'b1011;
        3:       control_flow_ex = 4'b0100;
        default: control_flow_ex = 4'b0000;
      endcase
      if (kind >= 2)
        ready_go_ex = ((expAllow && !flush) || (flush && canCancel)) && ($urandom_range(0, 3) != 0);
      else
        ready_go_ex = (kind != 0) && ($urandom_range(0, 3) != 0);
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
